// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Two-port arbiter and access sequencer for the 16x8 data memory. The CPU
// control path and the external host port share the memory; each access is
// walked through a three-state FSM (IDLE -> ACCESS [-> RDATA] -> IDLE) that
// drives the memory strobes, address and write data. When both ports request
// in the same IDLE cycle the port that did not own the previous access wins,
// so neither side can starve the other.
//
// Ports
//   clk_i, rst_i             clock (rising edge) and synchronous active-high reset
//   cpu_req_i / host_req_i   access request, level, held until the grant pulse
//   *_we_i                   1 = write, 0 = read
//   *_addr_i, *_wdata_i      access address and write data
//   *_gnt_o                  one-cycle grant pulse, high while the access issues
//   *_rvalid_o               one-cycle pulse, read data valid on *_rdata_o
//   *_rdata_o                last read data of that port, held between reads
//   mem_rd_o, mem_wr_o       memory read / write strobes (only in ACCESS)
//   mem_addr_o, mem_wdata_o  latched address / write data of the current access
//   mem_rdata_i              memory read data, valid the cycle after mem_rd_o
//   busy_o                   high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dm_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rdata_o,

  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [DW-1:0] host_wdata_i,
  output logic          host_gnt_o,
  output logic          host_rvalid_o,
  output logic [DW-1:0] host_rdata_o,

  output logic          mem_rd_o,
  output logic          mem_wr_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,

  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  owner_e        last_owner_q, last_owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;

  logic          pick_host;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // through the case statement leaves it unassigned (that would infer a latch).
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;

    // Host wins when it is the only requester, or on a tie when the CPU
    // owned the previous access.
    pick_host = host_req_i && (!cpu_req_i || (last_owner_q == OWN_CPU));

    unique case (state_q)
      IDLE: begin
        if (cpu_req_i || host_req_i) begin
          owner_d = pick_host ? OWN_HOST : OWN_CPU;
          we_d    = pick_host ? host_we_i    : cpu_we_i;
          addr_d  = pick_host ? host_addr_i  : cpu_addr_i;
          wdata_d = pick_host ? host_wdata_i : cpu_wdata_i;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        last_owner_d = owner_q;
        state_d      = we_q ? IDLE : RDATA;
      end

      RDATA: begin
        // Only the owner's read-data register is ever updated.
        if (owner_q == OWN_CPU) cpu_rdata_d  = mem_rdata_i;
        else                    host_rdata_d = mem_rdata_i;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: all state here is a handful of flops, so every register is given a
    // defined reset value; sequential state is updated with non-blocking
    // assignments so all flops see the same pre-edge values.
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_HOST;   // first tie after reset goes to the CPU
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cpu_gnt_o     = 1'b0;
    host_gnt_o    = 1'b0;
    cpu_rvalid_o  = 1'b0;
    host_rvalid_o = 1'b0;
    mem_rd_o      = 1'b0;
    mem_wr_o      = 1'b0;

    if (state_q == ACCESS) begin
      cpu_gnt_o  = (owner_q == OWN_CPU);
      host_gnt_o = (owner_q == OWN_HOST);
      mem_wr_o   = we_q;
      mem_rd_o   = !we_q;
    end

    // A reset arriving during RDATA aborts the read, so its valid pulse is
    // suppressed rather than announcing data the register will never keep.
    if ((state_q == RDATA) && !rst_i) begin
      cpu_rvalid_o  = (owner_q == OWN_CPU);
      host_rvalid_o = (owner_q == OWN_HOST);
    end
  end

  // Read data is valid in the RDATA cycle itself: the memory word is passed
  // straight through while it is being captured, then the register holds it.
  assign cpu_rdata_o  = cpu_rvalid_o  ? mem_rdata_i : cpu_rdata_q;
  assign host_rdata_o = host_rvalid_o ? mem_rdata_i : host_rdata_q;

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//
// Directed bench for dm_arbiter. A small synchronous 16x8 memory model sits on
// the memory port (read data appears the cycle after mem_rd_o). Inputs are
// driven and outputs sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cpu_req_i, cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic          cpu_gnt_o, cpu_rvalid_o;
  logic [DW-1:0] cpu_rdata_o;
  logic          host_req_i, host_we_i;
  logic [AW-1:0] host_addr_i;
  logic [DW-1:0] host_wdata_i;
  logic          host_gnt_o, host_rvalid_o;
  logic [DW-1:0] host_rdata_o;
  logic          mem_rd_o, mem_wr_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy_o;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem_model [16] = '{1: 8'h11, 2: 8'h22, 3: 8'h5A, default: 8'h00};

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_wr_o) mem_model[mem_addr_o] <= mem_wdata_o;
    if (mem_rd_o) mem_rdata <= mem_model[mem_addr_o];
  end

  dm_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_gnt_o    (cpu_gnt_o),
    .cpu_rvalid_o (cpu_rvalid_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .host_req_i   (host_req_i),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_gnt_o   (host_gnt_o),
    .host_rvalid_o(host_rvalid_o),
    .host_rdata_o (host_rdata_o),
    .mem_rd_o     (mem_rd_o),
    .mem_wr_o     (mem_wr_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata),
    .busy_o       (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_i = 1'b1;
    cpu_req_i = 1'b0;  cpu_we_i = 1'b0;  cpu_addr_i = '0;  cpu_wdata_i = '0;
    host_req_i = 1'b0; host_we_i = 1'b0; host_addr_i = '0; host_wdata_i = '0;

    // ---- Reset state ----
    step();
    check("rst_busy",    32'(busy_o),        32'd0);
    check("rst_cgnt",    32'(cpu_gnt_o),     32'd0);
    check("rst_hgnt",    32'(host_gnt_o),    32'd0);
    check("rst_crv",     32'(cpu_rvalid_o),  32'd0);
    check("rst_hrv",     32'(host_rvalid_o), 32'd0);
    check("rst_rd",      32'(mem_rd_o),      32'd0);
    check("rst_wr",      32'(mem_wr_o),      32'd0);
    check("rst_crdata",  32'(cpu_rdata_o),   32'h00);
    check("rst_hrdata",  32'(host_rdata_o),  32'h00);
    check("rst_addr",    32'(mem_addr_o),    32'h0);
    check("rst_wdata",   32'(mem_wdata_o),   32'h00);
    rst_i = 1'b0;

    // ---- CPU read of 0x3 (holds 0x5A) ----
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 4'h3;
    step();  // N+1
    check("rd_cgnt",  32'(cpu_gnt_o),  32'd1);
    check("rd_memrd", 32'(mem_rd_o),   32'd1);
    check("rd_memwr", 32'(mem_wr_o),   32'd0);
    check("rd_addr",  32'(mem_addr_o), 32'h3);
    check("rd_hgnt",  32'(host_gnt_o), 32'd0);
    check("rd_busy",  32'(busy_o),     32'd1);
    cpu_req_i = 1'b0;
    step();  // N+2
    check("rd_crv",    32'(cpu_rvalid_o),  32'd1);
    check("rd_cdata",  32'(cpu_rdata_o),   32'h5A);
    check("rd_strobe", 32'(mem_rd_o),      32'd0);
    check("rd_hrv",    32'(host_rvalid_o), 32'd0);
    step();  // N+3
    check("rd_idle",   32'(busy_o),        32'd0);
    check("rd_crv_lo", 32'(cpu_rvalid_o),  32'd0);
    check("rd_hold",   32'(cpu_rdata_o),   32'h5A);

    // ---- Host write 0x7C to 0xF, then CPU read of 0xF ----
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 4'hF; host_wdata_i = 8'h7C;
    step();
    check("wr_hgnt",  32'(host_gnt_o),  32'd1);
    check("wr_cgnt",  32'(cpu_gnt_o),   32'd0);
    check("wr_memwr", 32'(mem_wr_o),    32'd1);
    check("wr_memrd", 32'(mem_rd_o),    32'd0);
    check("wr_addr",  32'(mem_addr_o),  32'hF);
    check("wr_data",  32'(mem_wdata_o), 32'h7C);
    host_req_i = 1'b0;
    step();
    check("wr_idle",  32'(busy_o),      32'd0);
    check("wr_nostb", 32'(mem_wr_o),    32'd0);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 4'hF;
    step();
    check("wrd_cgnt", 32'(cpu_gnt_o), 32'd1);
    cpu_req_i = 1'b0;
    step();
    check("wrd_crv",   32'(cpu_rvalid_o), 32'd1);
    check("wrd_cdata", 32'(cpu_rdata_o),  32'h7C);
    check("wrd_hkeep", 32'(host_rdata_o), 32'h00);
    step();

    // ---- Simultaneous reads right after reset: CPU first ----
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rst2_cdata", 32'(cpu_rdata_o), 32'h00);
    cpu_req_i  = 1'b1; cpu_we_i  = 1'b0; cpu_addr_i  = 4'h1;
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 4'h2;
    step();
    check("tie1_cgnt", 32'(cpu_gnt_o),  32'd1);
    check("tie1_hgnt", 32'(host_gnt_o), 32'd0);
    check("tie1_addr", 32'(mem_addr_o), 32'h1);
    cpu_req_i = 1'b0;
    step();
    check("tie1_cdata", 32'(cpu_rdata_o), 32'h11);
    check("tie1_hgnt2", 32'(host_gnt_o),  32'd0);
    // CPU requests again, colliding with the waiting host at the next IDLE.
    cpu_req_i = 1'b1; cpu_addr_i = 4'h3;
    step();
    check("tie1_idle", 32'(busy_o), 32'd0);
    step();  // 3 cycles after the CPU grant
    check("tie2_hgnt", 32'(host_gnt_o), 32'd1);
    check("tie2_cgnt", 32'(cpu_gnt_o),  32'd0);
    check("tie2_addr", 32'(mem_addr_o), 32'h2);
    host_req_i = 1'b0;
    step();
    check("tie2_hrv",   32'(host_rvalid_o), 32'd1);
    check("tie2_hdata", 32'(host_rdata_o),  32'h22);
    check("tie2_ckeep", 32'(cpu_rdata_o),   32'h11);
    step();
    check("tie2_idle", 32'(busy_o), 32'd0);
    step();
    check("tie3_cgnt", 32'(cpu_gnt_o), 32'd1);
    cpu_req_i = 1'b0;
    step();
    check("tie3_cdata", 32'(cpu_rdata_o), 32'h5A);
    step();

    // ---- CPU streaming writes while the host requests ----
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 4'h4; cpu_wdata_i = 8'hA4;
    step();
    check("strm_cgnt1", 32'(cpu_gnt_o),   32'd1);
    check("strm_wr1",   32'(mem_wr_o),    32'd1);
    check("strm_dat1",  32'(mem_wdata_o), 32'hA4);
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 4'hF;
    cpu_addr_i = 4'h5; cpu_wdata_i = 8'hB5;
    step();
    check("strm_idle", 32'(busy_o),     32'd0);
    check("strm_nogn", 32'(cpu_gnt_o),  32'd0);
    step();  // host waited 2 cycles
    check("strm_hgnt", 32'(host_gnt_o), 32'd1);
    check("strm_cgnt", 32'(cpu_gnt_o),  32'd0);
    host_req_i = 1'b0;
    step();
    check("strm_hdata", 32'(host_rdata_o), 32'h7C);
    step();
    step();
    check("strm_cgnt2", 32'(cpu_gnt_o),   32'd1);
    check("strm_addr2", 32'(mem_addr_o),  32'h5);
    check("strm_dat2",  32'(mem_wdata_o), 32'hB5);
    cpu_req_i = 1'b0;
    step();

    // ---- Reset during RDATA of a host read ----
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 4'h4;
    step();
    check("hrst_hgnt", 32'(host_gnt_o), 32'd1);
    host_req_i = 1'b0;
    step();  // RDATA
    rst_i = 1'b1;
    #1;
    check("hrst_norv", 32'(host_rvalid_o), 32'd0);
    step();
    rst_i = 1'b0;
    check("hrst_idle",  32'(busy_o),        32'd0);
    check("hrst_norv2", 32'(host_rvalid_o), 32'd0);
    check("hrst_hdata", 32'(host_rdata_o),  32'h00);
    check("hrst_nord",  32'(mem_rd_o),      32'd0);

    // ---- One-cycle host req during CPU ACCESS is ignored ----
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 4'h3;
    step();
    check("ign_cgnt", 32'(cpu_gnt_o), 32'd1);
    cpu_req_i  = 1'b0;
    host_req_i = 1'b1; host_addr_i = 4'h2;
    step();
    host_req_i = 1'b0;
    check("ign_cdata", 32'(cpu_rdata_o), 32'h5A);
    step();
    check("ign_idle1", 32'(busy_o), 32'd0);
    step();
    check("ign_nohg",  32'(host_gnt_o),   32'd0);
    check("ign_idle2", 32'(busy_o),       32'd0);
    check("ign_hkeep", 32'(host_rdata_o), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer for the 16×8 data memory. It shares the memory between the CPU control path and an external host port, which is used for loading data and for dumps. Each access runs through a small FSM that drives the memory strobes, address and write data. Read data is returned to the requester on a registered one-cycle pulse. Simultaneous requests are resolved round-robin, so neither port can starve the other.

## Interface
- AW, 4, data memory address width
- DW, 8, data word width

- clk_i  in  1  clock; all logic acts on rising edge
- rst_i  in  1  reset, synchronous, active-high
- cpu_req_i  in  1  CPU access request; level, held until cpu_gnt_o
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_addr_i  in  AW  CPU address
- cpu_wdata_i  in  DW  CPU write data
- cpu_gnt_o  out  1  one-cycle grant pulse; the access is issued this cycle
- cpu_rvalid_o  out  1  one-cycle pulse; cpu_rdata_o is valid
- cpu_rdata_o  out  DW  last CPU read data; held between reads
- host_req_i, host_we_i, host_addr_i, host_wdata_i  in  1/1/AW/DW  host port, same semantics as the CPU port
- host_gnt_o, host_rvalid_o  out  1  host grant and read-valid pulses
- host_rdata_o  out  DW  last host read data; held between reads
- mem_rd_o  out  1  memory read strobe
- mem_wr_o  out  1  memory write strobe
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_rdata_i  in  DW  memory read data; valid on the cycle after mem_rd_o
- busy_o  out  1  1 whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, ACCESS, RDATA.
- IDLE:
  - Samples both request inputs at each edge.
  - If neither is set, stays in IDLE.
  - If exactly one is set, selects that port.
  - If both are set, selects the port that is not last_owner.
  - On a selection: latches the port's we, addr and wdata into internal registers, records owner, and goes to ACCESS.
- ACCESS:
  - Asserts the owner's gnt pulse.
  - Drives mem_addr_o and mem_wdata_o from the latched registers.
  - Asserts mem_wr_o if the latched we is 1, otherwise mem_rd_o.
  - Sets last_owner to owner.
  - Next state: RDATA for a read, IDLE for a write.
- RDATA:
  - Captures mem_rdata_i into the owner's rdata register.
  - Pulses the owner's rvalid.
  - Next state: IDLE.
- Exactly one of mem_rd_o and mem_wr_o is high, and only in ACCESS. Both are 0 in IDLE and RDATA.
- Request inputs are ignored outside IDLE.
- A losing requester keeps its req high and is granted at the next IDLE arbitration.
- The rdata register of the port that does not own the access is never modified.
- mem_addr_o and mem_wdata_o hold the latched values in every state. They are don't-care whenever the strobes are low.

## Timing
- Reset values: state IDLE, last_owner = host (so the first tie goes to the CPU).
- Outputs at reset: all gnt, rvalid and strobe outputs 0; busy_o 0; both rdata registers 0; latched addr and wdata 0.
- Read latency, with req sampled in IDLE at edge N:
  - gnt and mem_rd_o high during cycle N+1.
  - rvalid high and rdata valid during cycle N+2.
  - FSM back in IDLE for cycle N+3.
- Write latency: gnt and mem_wr_o high during cycle N+1; back in IDLE for cycle N+2.
- Throughput: 3 cycles per read and 2 cycles per write. There are no back-to-back grants; at least one IDLE cycle separates grants.
- Worst-case wait for a port holding req: one transaction of the other port plus its own arbitration cycle, i.e. at most 4 cycles from req to gnt.
- Write followed by a read of the same address, in either port order: the read returns the new data because accesses are strictly serialised.
- Reset asserted mid-operation (ACCESS or RDATA):
  - The next edge forces IDLE and clears both rdata registers.
  - No strobe or pulse is driven in the cycle after reset.
  - The aborted write may or may not have reached memory.
- A req deasserted before being sampled in IDLE produces no access. A req sampled in IDLE always completes, even if dropped afterwards.

## Test plan
- Reset, then CPU read of address 0x3 with memory holding 0x5A: cpu_gnt_o and mem_rd_o high at N+1; cpu_rvalid_o high with cpu_rdata_o = 0x5A at N+2; busy_o low at N+3.
- Host write of 0x7C to 0xF, then CPU read of 0xF: mem_wr_o at N+1 with addr 0xF and data 0x7C; the CPU read returns 0x7C.
- Both ports request reads at the same edge immediately after reset: CPU granted first and host granted 3 cycles later. Repeat the simultaneous request: host granted first (alternation).
- CPU holds req continuously with writes while the host requests: grants alternate CPU, host, CPU; the host waits no more than 4 cycles.
- Assert rst_i during RDATA of a host read: no host_rvalid_o pulse, host_rdata_o = 0x00, and IDLE on the next cycle.
- Pulse req for one cycle during ACCESS of the other port: the request is ignored and no grant is issued for it.
